// File: rtl/sccb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sccb_pkg                                                             |
// | Shared FSM state encoding and device ID constants for sccb_responder.|
// | Optional read path: SCCB_READ_EN                                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sccb_pkg;

  localparam logic [6:0] SCCB_DEV_ID = 7'h21;

  function automatic logic [7:0] sccb_wr_id(input logic [6:0] dev_id);
    return {dev_id, 1'b0};
  endfunction

  function automatic logic [7:0] sccb_rd_id(input logic [6:0] dev_id);
    return {dev_id, 1'b1};
  endfunction

  localparam logic [7:0] SCCB_WR_ID = sccb_wr_id(SCCB_DEV_ID);
  localparam logic [7:0] SCCB_RD_ID = sccb_rd_id(SCCB_DEV_ID);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ID        = 4'd1,
    ST_ID_ACK    = 4'd2,
    ST_SUB       = 4'd3,
    ST_SUB_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
`ifdef SCCB_READ_EN
    ST_RDATA     = 4'd7,
    ST_RD_NACK   = 4'd8,
`endif
    ST_IGNORE    = 4'd9
  } sccb_state_e;

endpackage
`default_nettype wire

// File: rtl/sccb_line_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sccb_line_filter                                                     |
// | 2-FF synchroniser, FILT_LEN-sample glitch filter, rise/fall strobes. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sccb_line_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [1:0] sync_q, sync_d;
  logic [3:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  // The level only moves once the synchronised input has disagreed with it
  // for FILT_LEN consecutive samples; any agreeing sample restarts the count.
  always_comb begin
    sync_d  = {sync_q[0], i_line};
    cnt_d   = 4'd0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == 4'(FILT_LEN - 1)) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
        fall_d  = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Idle bus level is high, so the filter starts there.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q  <= 2'b11;
      cnt_q   <= 4'd0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

endmodule
`default_nettype wire

// File: rtl/sccb_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sccb_responder                                                       |
// | SCCB slave: decodes 3-phase writes into a 256x8 shadow register file.|
// | Optional 2-phase read responder: SCCB_READ_EN                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEV_ID   = SCCB_DEV_ID,
  parameter int         FILT_LEN = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_SCL,
  input  logic       i_SDA,
  output logic       o_SDA_oe,
  output logic       o_wr_valid,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  input  logic [7:0] i_dbg_addr,
  output logic [7:0] o_dbg_data,
  output logic       o_busy,
  output logic       o_err
);

  localparam logic [7:0] WR_ID = sccb_wr_id(DEV_ID);
`ifdef SCCB_READ_EN
  localparam logic [7:0] RD_ID = sccb_rd_id(DEV_ID);
`endif

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  sccb_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_line  (i_SCL),
    .o_level (scl_lvl),
    .o_rise  (scl_rise),
    .o_fall  (scl_fall)
  );

  sccb_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_line  (i_SDA),
    .o_level (sda_lvl),
    .o_rise  (sda_rise),
    .o_fall  (sda_fall)
  );

  logic start_evt, stop_evt;
  assign start_evt = sda_fall & scl_lvl;
  assign stop_evt  = sda_rise & scl_lvl;

  sccb_state_e state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  sub_q, sub_d;
  logic [7:0]  sub_inc;
  logic        sda_oe_q, sda_oe_d;
  logic        wr_valid_q, wr_valid_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        wr_en;
  logic [7:0]  dbg_data_q, dbg_data_d;
`ifdef SCCB_READ_EN
  logic        rd_mode_q, rd_mode_d;
`endif

  // Shadow registers carry no reset; their power-up contents come from the
  // device configuration image.
  logic [7:0] regs_q [256];

  assign sub_inc = sub_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sub_d      = sub_q;
    sda_oe_d   = sda_oe_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    err_d      = err_q;
    wr_en      = 1'b0;
    dbg_data_d = regs_q[i_dbg_addr];
`ifdef SCCB_READ_EN
    rd_mode_d  = rd_mode_q;
`endif
    if (start_evt) begin
      // A repeated start that cuts a data byte short is a protocol error.
      if (state_q == ST_WDATA && bit_cnt_q != 4'd0) err_d = 1'b1;
      state_d   = ST_ID;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_evt) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ID, ST_SUB, ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b1;
            if (state_q == ST_ID) begin
              if (shift_q == WR_ID) begin
                state_d = ST_ID_ACK;
`ifdef SCCB_READ_EN
                rd_mode_d = 1'b0;
              end else if (shift_q == RD_ID) begin
                state_d   = ST_ID_ACK;
                rd_mode_d = 1'b1;
`endif
              end else begin
                state_d  = ST_IGNORE;
                sda_oe_d = 1'b0;
              end
            end else if (state_q == ST_SUB) begin
              sub_d   = shift_q;
              state_d = ST_SUB_ACK;
            end else begin
              state_d = ST_WDATA_ACK;
            end
          end
        end
        ST_ID_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
`ifdef SCCB_READ_EN
            if (rd_mode_q) begin
              state_d  = ST_RDATA;
              shift_d  = regs_q[sub_q];
              sda_oe_d = ~regs_q[sub_q][7];
            end else begin
              state_d  = ST_SUB;
              sda_oe_d = 1'b0;
            end
`else
            state_d  = ST_SUB;
            sda_oe_d = 1'b0;
`endif
          end
        end
        ST_SUB_ACK: begin
          if (scl_fall) begin
            state_d   = ST_WDATA;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
          end
        end
        ST_WDATA_ACK: begin
          if (scl_fall) begin
            wr_en      = 1'b1;
            wr_valid_d = 1'b1;
            wr_addr_d  = sub_q;
            wr_data_d  = shift_q;
            sub_d      = sub_inc;
            state_d    = ST_WDATA;
            bit_cnt_d  = 4'd0;
            sda_oe_d   = 1'b0;
          end
        end
`ifdef SCCB_READ_EN
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = ST_RD_NACK;
              bit_cnt_d = 4'd0;
              sda_oe_d  = 1'b0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        ST_RD_NACK: begin
          // The master's acknowledge bit lands in shift_q[0].
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_lvl};
          end else if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (shift_q[0]) begin
              state_d = ST_IGNORE;
            end else begin
              state_d  = ST_RDATA;
              sub_d    = sub_inc;
              shift_d  = regs_q[sub_inc];
              sda_oe_d = ~regs_q[sub_inc][7];
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      sub_q      <= 8'h00;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef SCCB_READ_EN
      rd_mode_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      sub_q      <= sub_d;
      sda_oe_q   <= sda_oe_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
`ifdef SCCB_READ_EN
      rd_mode_q  <= rd_mode_d;
`endif
    end
  end

  // Debug read samples before the write lands, so a same-cycle hit sees old data.
  always_ff @(posedge i_clk) begin
    if (wr_en) regs_q[sub_q] <= shift_q;
    dbg_data_q <= dbg_data_d;
  end

  assign o_SDA_oe   = sda_oe_q;
  assign o_wr_valid = wr_valid_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_dbg_data = dbg_data_q;
  assign o_busy     = busy_q;
  assign o_err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sccb_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sccb_responder                                                    |
// | Bit-banged SCCB master with write/read scoreboards for sccb_responder|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sccb_responder;
  import sccb_pkg::*;

  localparam int Q = 10;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_line;
  logic [7:0] dbg_addr = 8'h00;
  logic       oe, wr_valid, busy, err;
  logic [7:0] wr_addr, wr_data, dbg_data;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] wq[$];
  logic [7:0]  rq[$];

  assign sda_line = m_sda & ~oe;

  always #5 clk = ~clk;

  sccb_responder dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_SCL      (scl),
    .i_SDA      (sda_line),
    .o_SDA_oe   (oe),
    .o_wr_valid (wr_valid),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data),
    .o_busy     (busy),
    .o_err      (err)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every write pulse must match the oldest expected {addr,data}.
  always @(negedge clk) begin
    if (!rst && wr_valid === 1'b1) begin
      check("wr_pending", 16'(wq.size() != 0), 16'd1);
      if (wq.size() != 0) check("wr_pair", {wr_addr, wr_data}, wq.pop_front());
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; clks(Q);
    scl = 1'b1;   clks(Q);
    m_sda = 1'b0; clks(Q);
    scl = 1'b0;   clks(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; clks(Q);
    scl = 1'b1;   clks(Q);
    m_sda = 1'b1; clks(Q);
  endtask

  task automatic bit_cycle(input logic drv, input logic glitch, output logic ln, output logic oe_s);
    m_sda = drv; clks(Q);
    scl = 1'b1;  clks(Q / 2);
    if (glitch) begin
      m_sda = ~drv; clks(1);
      m_sda = drv;
    end
    ln = sda_line;
    oe_s = oe;
    clks(Q - Q / 2);
    scl = 1'b0;  clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag, input int gbit);
    logic ln, oe_s, any_oe;
    any_oe = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(b[i], i == gbit, ln, oe_s);
      any_oe |= oe_s;
    end
    check($sformatf("%s_data_oe", tag), 16'(any_oe), 16'd0);
    bit_cycle(1'b1, 1'b0, ln, oe_s);
    check($sformatf("%s_ack", tag), 16'(oe_s), 16'(exp_ack));
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic nack);
    logic ln, oe_s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, 1'b0, ln, oe_s);
      b[i] = ln;
    end
    bit_cycle(nack, 1'b0, ln, oe_s);
    check("rd_nack_oe", 16'(oe_s), 16'd0);
  endtask

  task automatic dbg_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
    dbg_addr = a; clks(2);
    check(tag, 16'(dbg_data), 16'(exp));
  endtask

  initial begin
    logic [7:0] rb;
    logic       ln, oe_s;

    clks(3);
    check("rst_oe", 16'(oe), 16'd0);
    check("rst_wr_valid", 16'(wr_valid), 16'd0);
    check("rst_wr_addr", 16'(wr_addr), 16'h00);
    check("rst_wr_data", 16'(wr_data), 16'h00);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_err", 16'(err), 16'd0);
    rst = 1'b0;
    clks(20);

    // Single write 42/12/80
    bus_start();
    check("busy_after_start", 16'(busy), 16'd1);
    send_byte(SCCB_WR_ID, 1'b1, "w1_id", -1);
    send_byte(8'h12, 1'b1, "w1_sub", -1);
    wq.push_back(16'h1280);
    send_byte(8'h80, 1'b1, "w1_data", -1);
    bus_stop();
    clks(20);
    check("w1_busy_after_stop", 16'(busy), 16'd0);
    check("w1_all_written", 16'(wq.size()), 16'd0);
    check("w1_wr_addr_hold", 16'(wr_addr), 16'h12);
    dbg_read(8'h12, 8'h80, "dbg_12");

    // Burst with sub-address wrap
    bus_start();
    send_byte(8'h42, 1'b1, "b_id", -1);
    send_byte(8'hFF, 1'b1, "b_sub", -1);
    wq.push_back(16'hFF11);
    send_byte(8'h11, 1'b1, "b_d0", -1);
    wq.push_back(16'h0022);
    send_byte(8'h22, 1'b1, "b_d1", -1);
    bus_stop();
    clks(20);
    check("b_all_written", 16'(wq.size()), 16'd0);
    check("b_wr_addr", 16'(wr_addr), 16'h00);
    check("b_wr_data", 16'(wr_data), 16'h22);
    dbg_read(8'hFF, 8'h11, "dbg_FF");
    dbg_read(8'h00, 8'h22, "dbg_00");

    // Foreign ID: never acknowledged, never written
    bus_start();
    send_byte(8'h60, 1'b0, "f_id", -1);
    send_byte(8'h12, 1'b0, "f_sub", -1);
    send_byte(8'h34, 1'b0, "f_data", -1);
    bus_stop();
    clks(20);
    check("f_wr_addr_unchanged", 16'(wr_addr), 16'h00);
    dbg_read(8'h12, 8'h80, "f_dbg_12");

    // One-cycle SDA glitch low while idle with SCL high
    m_sda = 1'b0; clks(1);
    m_sda = 1'b1; clks(20);
    check("glitch_idle_busy", 16'(busy), 16'd0);

    // One-cycle SDA glitch high during a 0 bit with SCL high
    bus_start();
    send_byte(8'h42, 1'b1, "g_id", 7);
    check("glitch_mid_busy", 16'(busy), 16'd1);
    send_byte(8'h05, 1'b1, "g_sub", -1);
    wq.push_back(16'h055A);
    send_byte(8'h5A, 1'b1, "g_data", -1);
    bus_stop();
    clks(20);
    check("g_all_written", 16'(wq.size()), 16'd0);

`ifdef SCCB_READ_EN
    bus_start();
    send_byte(8'h42, 1'b1, "p_id", -1);
    send_byte(8'h0A, 1'b1, "p_sub", -1);
    wq.push_back(16'h0A76);
    send_byte(8'h76, 1'b1, "p_data", -1);
    bus_stop();
    bus_start();
    send_byte(8'h42, 1'b1, "r_wid", -1);
    send_byte(8'h0A, 1'b1, "r_sub", -1);
    bus_stop();
    bus_start();
    send_byte(SCCB_RD_ID, 1'b1, "r_rid", -1);
    rq.push_back(8'h76);
    recv_byte(rb, 1'b1);
    check("rd_byte", 16'(rb), 16'(rq.pop_front()));
    bus_stop();
    clks(20);
    check("rd_busy_after_stop", 16'(busy), 16'd0);
`else
    bus_start();
    send_byte(8'h43, 1'b0, "r_rid_foreign", -1);
    bus_stop();
    clks(20);
`endif

    // Reset in the middle of a data byte
    bus_start();
    send_byte(8'h42, 1'b1, "x_id", -1);
    send_byte(8'h20, 1'b1, "x_sub", -1);
    for (int i = 0; i < 4; i++) bit_cycle(1'b1, 1'b0, ln, oe_s);
    m_sda = 1'b1;
    rst = 1'b1;
    clks(1);
    check("x_rst_oe", 16'(oe), 16'd0);
    check("x_rst_busy", 16'(busy), 16'd0);
    clks(2);
    rst = 1'b0;
    clks(20);
    bus_start();
    send_byte(8'h42, 1'b1, "c_id", -1);
    send_byte(8'h01, 1'b1, "c_sub", -1);
    wq.push_back(16'h0102);
    send_byte(8'h02, 1'b1, "c_data", -1);
    bus_stop();
    clks(20);
    check("c_all_written", 16'(wq.size()), 16'd0);
    dbg_read(8'h01, 8'h02, "dbg_01");
    check("err_before", 16'(err), 16'd0);

    // Repeated start mid-WDATA sets the sticky error and writes nothing
    bus_start();
    send_byte(8'h42, 1'b1, "e_id", -1);
    send_byte(8'h30, 1'b1, "e_sub", -1);
    for (int i = 0; i < 3; i++) bit_cycle(1'b0, 1'b0, ln, oe_s);
    bus_start();
    check("err_set", 16'(err), 16'd1);
    bus_stop();
    clks(20);
    check("err_sticky", 16'(err), 16'd1);
    check("final_no_pending", 16'(wq.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sccb_responder.md
# sccb_responder

SCCB (I2C-style) slave responder that sits on the same SIOC/SIOD pair as the camera configuration master. It decodes 3-phase write transactions into an internal 256x8 shadow register file and, optionally, answers 2-phase reads. It serves as an on-FPGA stand-in for the OV7670 during bring-up and as a bus monitor that shows exactly which register/value pairs the configuration master emitted.

## Interface
- `DEV_ID`, 7'h21: 7-bit device address. The write ID byte is 8'h42 and the read ID byte is 8'h43.
- `FILT_LEN`, 4: number of consecutive identical `i_clk` samples needed before a filtered SIOC/SIOD level changes (range 1..15).
- `i_clk`  in  1  system clock, ≥ 8× SIOC rate.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_SCL`  in  1  raw SIOC from the pin; asynchronous to `i_clk`.
- `i_SDA`  in  1  raw SIOD from the pin (open-drain, read back).
- `o_SDA_oe`  out  1  1 = pull SIOD low, 0 = release it.
- `o_wr_valid`  out  1  one-cycle pulse on each completed register write.
- `o_wr_addr`  out  8  sub-address of the last write.
- `o_wr_data`  out  8  data byte of the last write.
- `i_dbg_addr`  in  8  debug read address into the shadow registers.
- `o_dbg_data`  out  8  shadow register at `i_dbg_addr`, registered, 1-cycle latency.
- `o_busy`  out  1  high from START to STOP.
- `o_err`  out  1  sticky; set by a protocol violation, cleared only by `i_rst`.

## Operation
- **Line conditioning.** Each line is 2-FF synchronised, then passed through a `FILT_LEN` glitch filter.
- **Events** (computed on filtered levels):
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - The block samples a bit on each SCL rise and shifts on each SCL fall.
- **FSM states:** IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_NACK, IGNORE.
- **START from any state** clears the bit counter and enters ID. This is a repeated start. If the previous state was WDATA mid-byte, set `o_err`.
- **STOP from any state** enters IDLE. A STOP before WDATA_ACK completes produces no write and leaves the pending sub-address stored.
- **ID byte**, 8 bits MSB first:
  - 8'h42: go to ID_ACK, then SUB.
  - 8'h43 with reads enabled: go to ID_ACK, then RDATA.
  - Any other value: go to IGNORE, with SIOD never driven until the next START/STOP.
- **ID_ACK, SUB_ACK, WDATA_ACK (don't-care bit):** assert `o_SDA_oe` from the SCL fall after bit 8 until the following SCL fall.
- **SUB** latches the sub-address. After SUB_ACK the next byte goes to WDATA.
- **WDATA_ACK:** write the register file at the sub-address and pulse `o_wr_valid`. The sub-address then increments modulo 256, so 8'hFF wraps to 8'h00. Further bytes continue as WDATA.
- **RDATA:** drive `o_SDA_oe = ~bit` for register[sub-address], MSB first, each bit changing on the SCL fall. RD_NACK releases SIOD.
  - Master NA (SDA high) returns to IGNORE.
  - Master ACK increments the address and sends the next byte.
- **Register file:** never reset; it powers up as 8'h00 through FPGA init. Simultaneous debug read and write of the same address returns the old value.

## Timing
- Reset values: `o_SDA_oe`=0, `o_wr_valid`=0, `o_wr_addr`=8'h00, `o_wr_data`=8'h00, `o_busy`=0, `o_err`=0, FSM=IDLE.
- Event detection latency from the pin is 2 sync + `FILT_LEN` + 1 edge cycles.
- Driving SIOD: `o_SDA_oe` changes 1 cycle after the filtered SCL fall is detected, and never while filtered SCL is high.
- `o_wr_valid` rises exactly 1 cycle after the SCL fall that ends the WDATA_ACK bit. `o_wr_addr`/`o_wr_data` update in the same cycle and hold until the next write.
- `i_rst` mid-transfer immediately releases SIOD and returns to IDLE. The remainder of the transaction is ignored until the next START.

## Configuration
- `SCCB_READ_EN` defined: the read ID, RDATA and RD_NACK logic is compiled in.
- `SCCB_READ_EN` undefined: 8'h43 is treated as a foreign ID (IGNORE), and the RDATA/RD_NACK states do not exist.

## Structure
- Package `sccb_pkg`: FSM state enum, and the constants `SCCB_WR_ID`/`SCCB_RD_ID` derived from `DEV_ID`.
- Sub-module `sccb_line_filter`, instantiated once per line: synchroniser, glitch filter, rise/fall strobes.

## Test plan
- Write 42/12/80 → one `o_wr_valid`, addr 8'h12, data 8'h80, SIOD pulled low on all three don't-care bits; debug read of 8'h12 returns 8'h80.
- Burst 42/FF/11/22 → two writes: FF←11, then 00←22 (wrap).
- ID 8'h60 then 12/34 → no write, `o_SDA_oe` stays 0 throughout.
- 1-cycle SDA glitch while SCL high (`FILT_LEN`=4) → no START/STOP, FSM unchanged.
- With `SCCB_READ_EN`: write 42/0A, STOP, then 43 followed by a read byte with NA, after preloading 0A=76 → bits read on SIOD are 0111_0110.
- Reset asserted mid-WDATA → `o_SDA_oe`=0, `o_busy`=0, no write; a following clean 42/01/02 writes normally.
